// File: rtl/shift_pkg.sv
// Shared constants, op encodings and FSM state type for the multi-cycle shifter.
package shift_pkg;

    localparam int SHIFT_W = 16;
    localparam int CNT_W   = 4;

    localparam logic [1:0] OP_SHL = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_ROL = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_pkg

// File: rtl/bit_op_multiplexor.sv
// One-bit shift/rotate stage; purely combinational.
// val1 is the bit inserted at the LSB on SHL, val2 the bit inserted at the MSB on SHR.
module bit_op_multiplexor
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] a,
    input  logic               val1,
    input  logic               val2,
    input  logic [1:0]         sel,
    output logic [SHIFT_W-1:0] y
);

    // Select one of the four single-position shift/rotate results.
    always_comb begin
        y = a;
        case (sel)
            OP_SHL:  y = {a[SHIFT_W-2:0], val1};
            OP_SHR:  y = {val2, a[SHIFT_W-1:1]};
            OP_ROL:  y = {a[SHIFT_W-2:0], a[SHIFT_W-1]};
            OP_ROR:  y = {a[0], a[SHIFT_W-1:1]};
            default: y = a;
        endcase
    end

endmodule : bit_op_multiplexor

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: loads an operand, then iterates the one-bit
// stage once per clock for a programmed count with a start/busy/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; result/carry hold the last outcome
// ST_SHIFT | one stage iteration per clock until the count runs out
// ST_DONE  | result valid, done pulsed; a start here is accepted at once
module shift_sequencer
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [CNT_W-1:0]   amount,
    input  logic               fill,
    input  logic [SHIFT_W-1:0] data_in,
    output logic               busy,
    output logic               done,
    output logic [SHIFT_W-1:0] result,
    output logic               carry
);

    state_t             state_q,  state_d;
    logic [1:0]         op_q,     op_d;
    logic               fill_q,   fill_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [SHIFT_W-1:0] result_q, result_d;
    logic               carry_q,  carry_d;
    logic [SHIFT_W-1:0] stage_y;

    bit_op_multiplexor u_stage (
        .a    (result_q),
        .val1 (fill_q),
        .val2 (fill_q),
        .sel  (op_q),
        .y    (stage_y)
    );

    // Next-state, operand latch, iteration and carry extraction.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d     = op;
                    fill_d   = fill;
                    cnt_d    = amount;
                    result_d = data_in;
                    carry_d  = 1'b0;
                    state_d  = (amount == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_d = stage_y;
                // Left ops push out the MSB, right ops the LSB.
                if (op_q == OP_SHL || op_q == OP_ROL) begin
                    carry_d = result_q[SHIFT_W-1];
                end else begin
                    carry_d = result_q[0];
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SHL;
            fill_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Handshake flags decode straight from the registered state.
    always_comb begin
        busy   = (state_q == ST_SHIFT);
        done   = (state_q == ST_DONE);
        result = result_q;
        carry  = carry_q;
    end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, random ops
// against an arithmetic reference model, and hand-written handshake corners.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic        fill;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;

    int total = 0;
    int bad   = 0;

    shift_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .fill    (fill),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amount;
        logic        fill;
        logic [15:0] data;
        logic [15:0] exp_result;
        logic        exp_carry;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Whole-operation reference: n shifts applied at once with wide arithmetic.
    function automatic void model(input logic [1:0] o, input logic [3:0] n, input logic f,
                                  input logic [15:0] d, output logic [15:0] r, output logic c);
        logic [31:0] w;
        logic [15:0] lo_mask;
        logic [15:0] hi_mask;
        r = d;
        c = 1'b0;
        if (n != 0) begin
            lo_mask = 16'((17'h1 << n) - 17'h1);
            hi_mask = ~(16'hFFFF >> n);
            case (o)
                2'd0: begin
                    w = {16'h0, d} << n;
                    r = w[15:0] | (f ? lo_mask : 16'h0);
                    c = w[16];
                end
                2'd1: begin
                    w = {d, 16'h0} >> n;
                    r = w[31:16] | (f ? hi_mask : 16'h0);
                    c = w[15];
                end
                2'd2: begin
                    w = {d, d} << n;
                    r = w[31:16];
                    c = r[0];
                end
                default: begin
                    w = {d, d} >> n;
                    r = w[15:0];
                    c = r[15];
                end
            endcase
        end
    endfunction

    // Runs one operation. b2b: caller is already at the negedge of a DONE cycle.
    // pulse_mid: re-pulse start with other data during the first SHIFT cycle.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [3:0] n,
                         input logic f, input logic [15:0] d, input logic [15:0] er,
                         input logic ec, input bit b2b, input bit pulse_mid);
        int lat;
        int busy_cnt;
        if (!b2b) @(negedge clk);
        start   = 1'b1;
        op      = o;
        amount  = n;
        fill    = f;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        amount  = 4'($urandom);
        fill    = 1'($urandom);
        data_in = 16'($urandom);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pulse_mid && k == 1) begin
                start   = 1'b1;
                data_in = 16'hFFFF;
                op      = 2'd0;
                amount  = 4'd1;
            end
            if (pulse_mid && k == 2) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({nm, " done_latency"}, lat, n + 1);
        chk({nm, " busy_cycles"}, busy_cnt, n);
        chk({nm, " result"}, result, er);
        chk({nm, " carry"}, carry, ec);
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] hold_r;
        logic        hold_c;
        logic [15:0] mr;
        logic        mc;
        logic [1:0]  ro;
        logic [3:0]  rn;
        logic        rf;
        logic [15:0] rd;
        int          seen_done;

        vecs[0] = '{2'd0, 4'd4,  1'b0, 16'h1234, 16'h2340, 1'b1};
        vecs[1] = '{2'd3, 4'd1,  1'b0, 16'h0001, 16'h8000, 1'b1};
        vecs[2] = '{2'd1, 4'd15, 1'b1, 16'h8000, 16'hFFFF, 1'b0};
        vecs[3] = '{2'd2, 4'd0,  1'b0, 16'hABCD, 16'hABCD, 1'b0};
        vecs[4] = '{2'd0, 4'd8,  1'b1, 16'h00FF, 16'hFFFF, 1'b0};
        vecs[5] = '{2'd3, 4'd4,  1'b0, 16'h1234, 16'h4123, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; amount = 4'd0; fill = 1'b0; data_in = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset result", result, 16'h0);
        chk("reset carry", carry, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amount, vecs[i].fill,
                  vecs[i].data, vecs[i].exp_result, vecs[i].exp_carry, 1'b0, 1'b0);
        end

        // done lasts one cycle; result/carry stay put in IDLE.
        hold_r = result;
        hold_c = carry;
        repeat (3) begin
            @(negedge clk);
            chk("idle done low", done, 1'b0);
            chk("idle result hold", result, hold_r);
            chk("idle carry hold", carry, hold_c);
        end

        // Ignored mid-SHIFT start, then back-to-back start in the DONE cycle.
        do_op("rol_mid", 2'd2, 4'd2, 1'b0, 16'h8001, 16'h0006, 1'b0, 1'b0, 1'b1);
        do_op("b2b_shr", 2'd1, 4'd4, 1'b0, 16'h00F0, 16'h000F, 1'b0, 1'b1, 1'b0);
        model(2'd0, 4'd3, 1'b1, 16'h5A5A, mr, mc);
        do_op("b2b_shl", 2'd0, 4'd3, 1'b1, 16'h5A5A, mr, mc, 1'b1, 1'b0);

        // Reset during the 2nd SHIFT cycle of a 10-shift op aborts it.
        @(negedge clk);
        start = 1'b1; op = 2'd2; amount = 4'd10; fill = 1'b0; data_in = 16'hC3A5;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("abort busy before rst", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort result", result, 16'h0);
        chk("abort carry", carry, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("abort no done", seen_done, 0);

        // Reset and start together: reset wins.
        start = 1'b1; rst = 1'b1; amount = 4'd0; data_in = 16'h1111;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst+start done", done, 1'b0);
        chk("rst+start result", result, 16'h0);

        do_op("post_rst", 2'd0, 4'd4, 1'b0, 16'h1234, 16'h2340, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            rn = 4'($urandom_range(0, 15));
            rf = 1'($urandom);
            rd = 16'($urandom);
            model(ro, rn, rf, rd, mr, mc);
            do_op($sformatf("rnd%0d", i), ro, rn, rf, rd, mr, mc, ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sequencer
